// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command controller: command bytes,
// default widths and the state encodings of the frame parser and the
// two-byte result transmitter.
package alu_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FUN_WIDTH  = 4;

  localparam logic [7:0] CMD_OPER   = 8'hCC;
  localparam logic [7:0] CMD_NOOPER = 8'hDD;

  // Frame parser / ALU sequencing states; the result transmission is one state.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_A    = 3'd1,
    ST_GET_B    = 3'd2,
    ST_GET_FUN  = 3'd3,
    ST_ALU_REQ  = 3'd4,
    ST_ALU_WAIT = 3'd5,
    ST_TX       = 3'd6
  } ctrl_state_e;

  // Two-byte transmit handshake states, low byte first.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_LO     = 3'd1,
    TX_LO_ACK = 3'd2,
    TX_HI     = 3'd3,
    TX_HI_ACK = 3'd4
  } tx_state_e;

endpackage

// File: rtl/alu_result_tx.sv
// Sends a 2*DATA_WIDTH result as two bytes (low byte first) through the
// UART transmit handshake: strobe when the transmitter is idle, then wait
// for its busy flag to rise and fall before moving on.
module alu_result_tx
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2*DATA_WIDTH-1:0] result,
  input  logic                    tx_busy,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  output logic                    done
);

  tx_state_e             state_r, state_nxt_s;
  logic                  seen_busy_r;
  logic                  load_lo_s, load_hi_s, done_s;
  logic [DATA_WIDTH-1:0] tx_data_r;
  logic                  tx_valid_r;

  // Next-state and strobe decode for the handshake sequence.
  always_comb begin
    state_nxt_s = state_r;
    load_lo_s   = 1'b0;
    load_hi_s   = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if (start) state_nxt_s = TX_LO;
        else       state_nxt_s = TX_IDLE;
      end
      TX_LO: begin
        if (!tx_busy) begin
          load_lo_s   = 1'b1;
          state_nxt_s = TX_LO_ACK;
        end else begin
          state_nxt_s = TX_LO;
        end
      end
      TX_LO_ACK: begin
        if (seen_busy_r && !tx_busy) state_nxt_s = TX_HI;
        else                         state_nxt_s = TX_LO_ACK;
      end
      TX_HI: begin
        if (!tx_busy) begin
          load_hi_s   = 1'b1;
          state_nxt_s = TX_HI_ACK;
        end else begin
          state_nxt_s = TX_HI;
        end
      end
      TX_HI_ACK: begin
        if (seen_busy_r && !tx_busy) begin
          done_s      = 1'b1;
          state_nxt_s = TX_IDLE;
        end else begin
          state_nxt_s = TX_HI_ACK;
        end
      end
      default: state_nxt_s = TX_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= TX_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Byte/strobe output registers and the busy-rise tracker of the ACK states.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data_r   <= '0;
      tx_valid_r  <= 1'b0;
      seen_busy_r <= 1'b0;
    end else begin
      tx_valid_r <= load_lo_s || load_hi_s;
      if (load_lo_s)      tx_data_r <= result[DATA_WIDTH-1:0];
      else if (load_hi_s) tx_data_r <= result[2*DATA_WIDTH-1:DATA_WIDTH];
      else                tx_data_r <= tx_data_r;
      if ((state_r == TX_LO_ACK) || (state_r == TX_HI_ACK)) begin
        if (tx_busy)          seen_busy_r <= 1'b1;
        else if (seen_busy_r) seen_busy_r <= 1'b0;
        else                  seen_busy_r <= seen_busy_r;
      end else begin
        seen_busy_r <= 1'b0;
      end
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign done     = done_s;

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: parses 0xCC A B FUN / 0xDD FUN frames from
// the UART receiver, issues a one-cycle ALU request, captures the result and
// hands it to alu_result_tx for two-byte transmission.
// Optional macro ALU_CMD_TIMEOUT_EN adds an ALU response watchdog that forces
// an all-ones result and pulses ERR.
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int FUN_WIDTH      = DEF_FUN_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VALID,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    ALU_EN,
  output logic                    ALU_CLK_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VALID,
  input  logic                    TX_BUSY,
  output logic                    ERR
);

  ctrl_state_e             state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0]   alu_a_r, alu_b_r;
  logic [FUN_WIDTH-1:0]    alu_fun_r;
  logic                    alu_en_r, alu_clk_en_r, err_r;
  logic [2*DATA_WIDTH-1:0] result_r;
  logic                    is_oper_s, is_nooper_s, fun_take_s;
  logic                    capture_s, timeout_s, tx_start_s, tx_done_s;

  assign is_oper_s   = RX_D_VALID && (RX_P_DATA == DATA_WIDTH'(CMD_OPER));
  assign is_nooper_s = RX_D_VALID && (RX_P_DATA == DATA_WIDTH'(CMD_NOOPER));
  assign fun_take_s  = (state_r == ST_GET_FUN) && RX_D_VALID;
  // Strobes that coincide with ALU_EN (ALU_REQ) are deliberately not seen here.
  assign capture_s   = (state_r == ST_ALU_WAIT) && ALU_OUT_VALID;
  assign tx_start_s  = capture_s || timeout_s;

`ifdef ALU_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_r;

  // Watchdog counter: zero outside ALU_WAIT so every entry starts fresh.
  always_ff @(posedge CLK) begin
    if (!RST)                        to_cnt_r <= '0;
    else if (state_r != ST_ALU_WAIT) to_cnt_r <= '0;
    else if (!ALU_OUT_VALID)         to_cnt_r <= to_cnt_r + TO_W'(1);
    else                             to_cnt_r <= to_cnt_r;
  end

  assign timeout_s = (state_r == ST_ALU_WAIT) && !ALU_OUT_VALID &&
                     (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TIMEOUT_CYCLES == 32'sd0);
  assign timeout_s            = 1'b0;
`endif

  // Frame parser and ALU sequencing next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (is_oper_s)        state_nxt_s = ST_GET_A;
        else if (is_nooper_s) state_nxt_s = ST_GET_FUN;
        else                  state_nxt_s = ST_IDLE;
      end
      ST_GET_A: begin
        if (RX_D_VALID) state_nxt_s = ST_GET_B;
        else            state_nxt_s = ST_GET_A;
      end
      ST_GET_B: begin
        if (RX_D_VALID) state_nxt_s = ST_GET_FUN;
        else            state_nxt_s = ST_GET_B;
      end
      ST_GET_FUN: begin
        if (RX_D_VALID) state_nxt_s = ST_ALU_REQ;
        else            state_nxt_s = ST_GET_FUN;
      end
      ST_ALU_REQ: state_nxt_s = ST_ALU_WAIT;
      ST_ALU_WAIT: begin
        if (tx_start_s) state_nxt_s = ST_TX;
        else            state_nxt_s = ST_ALU_WAIT;
      end
      ST_TX: begin
        if (tx_done_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_TX;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Operand/function latches, ALU request and clock gate, result capture, error pulse.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      alu_a_r      <= '0;
      alu_b_r      <= '0;
      alu_fun_r    <= '0;
      alu_en_r     <= 1'b0;
      alu_clk_en_r <= 1'b0;
      result_r     <= '0;
      err_r        <= 1'b0;
    end else begin
      if ((state_r == ST_GET_A) && RX_D_VALID) alu_a_r <= RX_P_DATA;
      else                                     alu_a_r <= alu_a_r;
      if ((state_r == ST_GET_B) && RX_D_VALID) alu_b_r <= RX_P_DATA;
      else                                     alu_b_r <= alu_b_r;
      if (fun_take_s) alu_fun_r <= RX_P_DATA[FUN_WIDTH-1:0];
      else            alu_fun_r <= alu_fun_r;
      alu_en_r <= fun_take_s;
      if (fun_take_s)      alu_clk_en_r <= 1'b1;
      else if (tx_start_s) alu_clk_en_r <= 1'b0;
      else                 alu_clk_en_r <= alu_clk_en_r;
      if (capture_s)      result_r <= ALU_OUT;
      else if (timeout_s) result_r <= '1;
      else                result_r <= result_r;
      err_r <= timeout_s;
    end
  end

  alu_result_tx #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_result_tx (
    .clk      (CLK),
    .rst_n    (RST),
    .start    (tx_start_s),
    .result   (result_r),
    .tx_busy  (TX_BUSY),
    .tx_data  (TX_P_DATA),
    .tx_valid (TX_D_VALID),
    .done     (tx_done_s)
  );

  assign ALU_A      = alu_a_r;
  assign ALU_B      = alu_b_r;
  assign ALU_FUN    = alu_fun_r;
  assign ALU_EN     = alu_en_r;
  assign ALU_CLK_EN = alu_clk_en_r;
  assign ERR        = err_r;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Testbench for alu_cmd_ctrl: directed frames plus randomized frames, with a
// behavioural ALU, a simple UART-TX busy model and a frame-level reference.
module tb_alu_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VALID;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, ALU_CLK_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VALID;
  logic        TX_BUSY;
  logic        ERR;

  int errors = 0;
  int checks = 0;

  // environment state
  int         cyc = 0;
  int         alu_mode = 0;   // 0: respond after 1 cycle, 1: spurious strobe with ALU_EN then respond, 2: never
  int         alu_pend = 0;
  logic [15:0] alu_res;
  int         en_cnt = 0, en_cyc = 0, err_cnt = 0, err_cyc = 0;
  int         busy_cnt = 0;
  bit         force_busy = 1'b0;
  logic [7:0] tx_q[$];

  // reference model state (frame level)
  logic [7:0] exp_a = 8'h00, exp_b = 8'h00;

  alu_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VALID(RX_D_VALID),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_CLK_EN(ALU_CLK_EN), .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .TX_P_DATA(TX_P_DATA), .TX_D_VALID(TX_D_VALID), .TX_BUSY(TX_BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return 16'(a & b);
      4'd4:    return 16'(a | b);
      default: return 16'(a ^ b);
    endcase
  endfunction

  // behavioural ALU
  always @(negedge CLK) begin
    if (alu_pend > 0) begin
      alu_pend = alu_pend - 1;
      ALU_OUT_VALID = (alu_pend == 0);
      if (alu_pend == 0) ALU_OUT = alu_res;
    end else begin
      ALU_OUT_VALID = 1'b0;
    end
    if (ALU_EN === 1'b1) begin
      en_cnt = en_cnt + 1;
      en_cyc = cyc;
      alu_res = alu_ref(ALU_A, ALU_B, ALU_FUN);
      if (alu_mode == 0) alu_pend = 1;
      if (alu_mode == 1) begin
        alu_pend = 3;
        ALU_OUT_VALID = 1'b1;
        ALU_OUT = 16'hBEEF;
      end
    end
  end

  // UART TX model and byte collector, ERR monitor
  always @(negedge CLK) begin
    if (TX_D_VALID === 1'b1) begin
      tx_q.push_back(TX_P_DATA);
      busy_cnt = 3;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    TX_BUSY = force_busy || (busy_cnt > 0);
    if (ERR === 1'b1) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VALID = 1'b1;
    @(negedge CLK);
    RX_D_VALID = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_alu_a", 32'(ALU_A), 32'h0);
    chk("rst_alu_b", 32'(ALU_B), 32'h0);
    chk("rst_alu_fun", 32'(ALU_FUN), 32'h0);
    chk("rst_alu_en", 32'(ALU_EN), 32'h0);
    chk("rst_clk_en", 32'(ALU_CLK_EN), 32'h0);
    chk("rst_tx_data", 32'(TX_P_DATA), 32'h0);
    chk("rst_tx_valid", 32'(TX_D_VALID), 32'h0);
    chk("rst_err", 32'(ERR), 32'h0);
    RST = 1'b1;
    exp_a = 8'h00;
    exp_b = 8'h00;
    tx_q.delete();
  endtask

  // issue a frame and check the request cycle right after the FUN byte
  task automatic do_frame(input bit oper, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] f, input int mode);
    alu_mode = mode;
    if (oper) begin
      send(8'hCC);
      send(a);
      send(b);
      exp_a = a;
      exp_b = b;
    end else begin
      send(8'hDD);
    end
    chk("clk_en_before_fun", 32'(ALU_CLK_EN), 32'h0);
    send(f);
    chk("alu_en_after_fun", 32'(ALU_EN), 32'h1);
    chk("clk_en_after_fun", 32'(ALU_CLK_EN), 32'h1);
    chk("alu_a", 32'(ALU_A), 32'(exp_a));
    chk("alu_b", 32'(ALU_B), 32'(exp_b));
    chk("alu_fun", 32'(ALU_FUN), 32'(f[3:0]));
  endtask

  task automatic collect(input logic [15:0] exp_res, input int en0);
    logic [7:0] lo, hi;
    for (int i = 0; i < 400 && tx_q.size() < 2; i++) @(negedge CLK);
    chk("tx_bytes_arrived", 32'(tx_q.size() >= 2), 32'h1);
    lo = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
    hi = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
    chk("tx_lo_byte", 32'(lo), 32'(exp_res[7:0]));
    chk("tx_hi_byte", 32'(hi), 32'(exp_res[15:8]));
    repeat (8) @(negedge CLK);
    chk("no_extra_tx", 32'(tx_q.size()), 32'h0);
    chk("one_alu_en", 32'(en_cnt - en0), 32'h1);
    chk("clk_en_off", 32'(ALU_CLK_EN), 32'h0);
  endtask

  initial begin
    int en0;
    int err0;
    logic [7:0] a, b, f, g;
    bit oper;

    RST = 1'b0;
    RX_P_DATA = 8'h00;
    RX_D_VALID = 1'b0;
    ALU_OUT = 16'h0000;
    ALU_OUT_VALID = 1'b0;
    TX_BUSY = 1'b0;

    do_reset();

    // basic full frame: 10 + 5
    en0 = en_cnt;
    do_frame(1'b1, 8'd10, 8'd5, 8'h00, 0);
    collect(16'h000F, en0);

    // reuse operands: 10 * 5
    en0 = en_cnt;
    do_frame(1'b0, 8'h00, 8'h00, 8'h02, 0);
    collect(16'h0032, en0);

    // garbage byte in IDLE then a frame with carry into the upper byte
    en0 = en_cnt;
    send(8'h55);
    repeat (4) @(negedge CLK);
    chk("garbage_no_alu_en", 32'(en_cnt - en0), 32'h0);
    chk("garbage_no_tx", 32'(tx_q.size()), 32'h0);
    do_frame(1'b1, 8'hFE, 8'h02, 8'h00, 0);
    collect(16'h0100, en0);

    // strobe coinciding with ALU_EN is ignored; FUN upper bits ignored
    en0 = en_cnt;
    do_frame(1'b1, 8'h3C, 8'h0F, 8'hA3, 1);
    collect(alu_ref(8'h3C, 8'h0F, 4'h3), en0);

    // transmitter held busy, bytes injected while result is pending/sent
    en0 = en_cnt;
    force_busy = 1'b1;
    do_frame(1'b1, 8'h21, 8'h12, 8'h01, 0);
    send(8'hCC);
    send(8'h77);
    send(8'hDD);
    send(8'h05);
    repeat (12) @(negedge CLK);
    chk("busy_holds_tx", 32'(tx_q.size()), 32'h0);
    chk("busy_no_valid", 32'(TX_D_VALID), 32'h0);
    force_busy = 1'b0;
    send(8'hCC);
    send(8'h99);
    collect(16'h000F, en0);
    // injected bytes must not have changed the operands
    en0 = en_cnt;
    do_frame(1'b0, 8'h00, 8'h00, 8'h00, 0);
    collect(16'h0033, en0);

    // randomized frames
    for (int i = 0; i < 10; i++) begin
      oper = ($urandom_range(0, 3) != 0);
      a = 8'($urandom);
      b = 8'($urandom);
      f = 8'($urandom);
      g = 8'($urandom);
      if (g == 8'hCC || g == 8'hDD) g = 8'h00;
      en0 = en_cnt;
      if ($urandom_range(0, 1) == 1) send(g);
      do_frame(oper, a, b, f, $urandom_range(0, 1));
      collect(alu_ref(exp_a, exp_b, f[3:0]), en0);
    end

    // ALU never answers
    en0 = en_cnt;
    err0 = err_cnt;
`ifdef ALU_CMD_TIMEOUT_EN
    do_frame(1'b0, 8'h00, 8'h00, 8'h01, 2);
    collect(16'hFFFF, en0);
    chk("err_one_pulse", 32'(err_cnt - err0), 32'h1);
    chk("err_latency", 32'(err_cyc - en_cyc), 32'd17);
`else
    do_frame(1'b0, 8'h00, 8'h00, 8'h01, 2);
    repeat (40) @(negedge CLK);
    chk("hang_no_tx", 32'(tx_q.size()), 32'h0);
    chk("hang_clk_en", 32'(ALU_CLK_EN), 32'h1);
    chk("hang_no_err", 32'(err_cnt - err0), 32'h0);
`endif

    // reset from wherever the FSM is, then operands restart from zero
    do_reset();
    en0 = en_cnt;
    do_frame(1'b0, 8'h00, 8'h00, 8'h00, 0);
    collect(16'h0000, en0);
    en0 = en_cnt;
    do_frame(1'b1, 8'h80, 8'h90, 8'h00, 0);
    collect(16'h0110, en0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
